// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with configurable data width, parity and stop bits.
// Build macro UART_RX_MAJORITY_EN selects a 2-of-3 vote around each bit centre instead of a single sample.
module uart_rx_param #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 rx_busy
);
    localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
`ifdef UART_RX_MAJORITY_EN
    localparam int START_DEC = OVERSAMPLE / 2;
`else
    localparam int START_DEC = OVERSAMPLE / 2 - 1;
`endif
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [SW-1:0] START_PT  = SW'(START_DEC);
    localparam logic [SW-1:0] BIT_PT    = SW'(OVERSAMPLE - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    if (DIV < 2) begin : g_div_check
        $error("uart_rx_param: CLK_FREQ/(BAUD_RATE*OVERSAMPLE) must be at least 2");
    end
    if ((OVERSAMPLE < 8) || ((OVERSAMPLE % 2) != 0)) begin : g_os_check
        $error("uart_rx_param: OVERSAMPLE must be even and at least 8");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9) || (PARITY < 0) || (PARITY > 2) ||
        (STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_frame_check
        $error("uart_rx_param: illegal DATA_BITS, PARITY or STOP_BITS");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    // Ones-count check of payload plus received parity bit against the configured mode.
    function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] d, input logic p);
        logic ones_odd;
        ones_odd = ^{d, p};
        if (PARITY == 1) begin
            return ~ones_odd;
        end else if (PARITY == 2) begin
            return ones_odd;
        end else begin
            return 1'b0;
        end
    endfunction

    state_e               state_q, state_d;
    logic                 rx_meta_q, rxs_q, rxs_prev_q;
    logic [DW-1:0]        div_q, div_d;
    logic [SW-1:0]        s_cnt_q, s_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_err_q, par_err_d;
    logic                 stop_err_q, stop_err_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_done_q, rx_done_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 rx_busy_q, rx_busy_d;
    logic                 tick_s, fall_s, bit_s, point_s;

    assign tick_s = (div_q == DIV_LAST);
    assign fall_s = rxs_prev_q & ~rxs_q;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] vote_q, vote_d;

    // Vote history: the samples taken on the two previous ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            vote_q <= 2'b11;
        end else begin
            vote_q <= vote_d;
        end
    end

    // 2-of-3 majority of the two stored samples and the current one.
    always_comb begin
        vote_d = tick_s ? {vote_q[0], rxs_q} : vote_q;
        bit_s  = (vote_q[1] & vote_q[0]) | (vote_q[1] & rxs_q) | (vote_q[0] & rxs_q);
    end
`else
    assign bit_s = rxs_q;
`endif

    assign point_s = tick_s && (s_cnt_q == ((state_q == ST_START) ? START_PT : BIT_PT));

    // Next-state and datapath: divider, sample counter, shifter and frame result.
    always_comb begin
        state_d      = state_q;
        div_d        = tick_s ? {DW{1'b0}} : div_q + DW'(1);
        s_cnt_d      = s_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        par_err_d    = par_err_q;
        stop_err_d   = stop_err_q;
        rx_data_d    = rx_data_q;
        rx_done_d    = 1'b0;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        if (tick_s) begin
            s_cnt_d = (s_cnt_q == BIT_PT) ? {SW{1'b0}} : s_cnt_q + SW'(1);
        end else begin
            s_cnt_d = s_cnt_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (fall_s) begin
                    state_d = ST_START;
                    div_d   = {DW{1'b0}};
                    s_cnt_d = {SW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (point_s && bit_s) begin
                    state_d = ST_IDLE;
                end else if (point_s) begin
                    state_d   = ST_DATA;
                    s_cnt_d   = {SW{1'b0}};
                    bit_cnt_d = 4'd0;
                    par_err_d = 1'b0;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (point_s) begin
                    shreg_d = {bit_s, shreg_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d  = 4'd0;
                        stop_err_d = 1'b0;
                        state_d    = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (point_s) begin
                    par_err_d = parity_mismatch(shreg_q, bit_s);
                    state_d   = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (point_s && (bit_cnt_q == STOP_LAST)) begin
                    rx_data_d    = shreg_q;
                    frame_err_d  = stop_err_q | ~bit_s;
                    parity_err_d = par_err_q;
                    rx_done_d    = 1'b1;
                    state_d      = ST_IDLE;
                end else if (point_s) begin
                    stop_err_d = stop_err_q | ~bit_s;
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        rx_busy_d = (state_d != ST_IDLE);
    end

    // All state, with the line synchroniser idling high out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q    <= 1'b1;
            rxs_q        <= 1'b1;
            rxs_prev_q   <= 1'b1;
            state_q      <= ST_IDLE;
            div_q        <= {DW{1'b0}};
            s_cnt_q      <= {SW{1'b0}};
            bit_cnt_q    <= 4'd0;
            shreg_q      <= {DATA_BITS{1'b0}};
            par_err_q    <= 1'b0;
            stop_err_q   <= 1'b0;
            rx_data_q    <= {DATA_BITS{1'b0}};
            rx_done_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            rx_busy_q    <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rxs_q        <= rx_meta_q;
            rxs_prev_q   <= rxs_q;
            state_q      <= state_d;
            div_q        <= div_d;
            s_cnt_q      <= s_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            par_err_q    <= par_err_d;
            stop_err_q   <= stop_err_d;
            rx_data_q    <= rx_data_d;
            rx_done_q    <= rx_done_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            rx_busy_q    <= rx_busy_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_done    = rx_done_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign rx_busy    = rx_busy_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: four channels (8N1, 8E1, 7E2, 5O2) at a reduced clock/baud ratio.
// Frames are built bit by bit and results are predicted from the frame contents by a ones-count model.
module tb_uart_rx_param;
    localparam int CLK_FREQ = 640_000;
    localparam int BAUD     = 10_000;
    localparam int OS       = 16;
    localparam int DIV      = CLK_FREQ / (BAUD * OS);
    localparam int BIT      = DIV * OS;

    function automatic int cfg_db(input int k);
        case (k)
            0: return 8;
            1: return 8;
            2: return 7;
            default: return 5;
        endcase
    endfunction
    function automatic int cfg_pa(input int k);
        case (k)
            0: return 0;
            1: return 2;
            2: return 2;
            default: return 1;
        endcase
    endfunction
    function automatic int cfg_sb(input int k);
        case (k)
            0: return 1;
            1: return 1;
            default: return 2;
        endcase
    endfunction

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_l [4];
    wire  [8:0] data_w [4];
    wire  [3:0] done_w, ferr_w, perr_w, busy_w;
    int         done_cnt [4] = '{0, 0, 0, 0};
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int DB = cfg_db(g);
        logic [DB-1:0] d_s;
        uart_rx_param #(
            .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
            .DATA_BITS(DB), .PARITY(cfg_pa(g)), .STOP_BITS(cfg_sb(g))
        ) u_dut (
            .clk(clk), .rst(rst), .rx(rx_l[g]), .rx_data(d_s), .rx_done(done_w[g]),
            .frame_err(ferr_w[g]), .parity_err(perr_w[g]), .rx_busy(busy_w[g])
        );
        assign data_w[g] = 9'(d_s);
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (done_w[i]) done_cnt[i] <= done_cnt[i] + 1;
        end
    end

    // Result outputs may only move in an rx_done cycle (reset excepted).
    logic [8:0] prev_data [4];
    logic [3:0] prev_f, prev_p;
    logic       prev_rst = 1'b1;
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst && !prev_rst &&
                ((data_w[i] !== prev_data[i]) || (ferr_w[i] !== prev_f[i]) || (perr_w[i] !== prev_p[i]))) begin
                n_checks++;
                if (done_w[i] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL hold ch%0d: outputs changed with rx_done=%b, required 1", i, done_w[i]);
                end
            end
            prev_data[i] = data_w[i];
        end
        prev_f   = ferr_w;
        prev_p   = perr_w;
        prev_rst = rst;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int k, input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            rx_l[k] = v;
            @(negedge clk);
        end
    endtask

    // One frame, one clock per step; optional inversion window [g_lo, g_lo+g_len) in clocks from the start edge.
    task automatic send(input int k, input logic [8:0] data, input logic pbit, input logic [1:0] stops,
                        input int g_lo, input int g_len);
        logic [12:0] bits;
        int nb;
        logic v;
        bits = '0;
        nb = 0;
        bits[nb] = 1'b0; nb++;
        for (int i = 0; i < cfg_db(k); i++) begin bits[nb] = data[i]; nb++; end
        if (cfg_pa(k) != 0) begin bits[nb] = pbit; nb++; end
        for (int i = 0; i < cfg_sb(k); i++) begin bits[nb] = stops[i]; nb++; end
        for (int c = 0; c < nb * BIT; c++) begin
            v = bits[c / BIT];
            if ((c >= g_lo) && (c < g_lo + g_len)) v = ~v;
            rx_l[k] = v;
            @(negedge clk);
        end
    endtask

    task automatic check_frame(input string name, input int k, input int cnt0,
                               input logic [8:0] ed, input logic ef, input logic ep);
        check({name, "/done_count"}, done_cnt[k] - cnt0, 1);
        check({name, "/rx_data"}, {23'd0, data_w[k]}, {23'd0, ed});
        check({name, "/frame_err"}, {31'd0, ferr_w[k]}, {31'd0, ef});
        check({name, "/parity_err"}, {31'd0, perr_w[k]}, {31'd0, ep});
        check({name, "/rx_busy"}, {31'd0, busy_w[k]}, 32'd0);
    endtask

    typedef struct {
        int         k;
        logic [8:0] data;
        logic       pbit;
        logic [1:0] stops;
        logic [8:0] exp_data;
        logic       exp_ferr;
        logic       exp_perr;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int cnt0, k, db, ones;
        logic [8:0] d, ed;
        logic p, ef, ep;
        logic [1:0] st;
        logic [8:0] glitch_exp;

        vecs[0]  = '{0, 9'h031, 1'b0, 2'b11, 9'h031, 1'b0, 1'b0};
        vecs[1]  = '{0, 9'h0A5, 1'b0, 2'b00, 9'h0A5, 1'b1, 1'b0};
        vecs[2]  = '{0, 9'h000, 1'b0, 2'b11, 9'h000, 1'b0, 1'b0};
        vecs[3]  = '{0, 9'h0FF, 1'b0, 2'b11, 9'h0FF, 1'b0, 1'b0};
        vecs[4]  = '{1, 9'h031, 1'b0, 2'b11, 9'h031, 1'b0, 1'b1};
        vecs[5]  = '{1, 9'h031, 1'b1, 2'b11, 9'h031, 1'b0, 1'b0};
        vecs[6]  = '{1, 9'h0A5, 1'b0, 2'b00, 9'h0A5, 1'b1, 1'b0};
        vecs[7]  = '{2, 9'h031, 1'b0, 2'b11, 9'h031, 1'b0, 1'b1};
        vecs[8]  = '{2, 9'h031, 1'b1, 2'b11, 9'h031, 1'b0, 1'b0};
        vecs[9]  = '{2, 9'h04F, 1'b1, 2'b01, 9'h04F, 1'b1, 1'b0};
        vecs[10] = '{3, 9'h015, 1'b0, 2'b11, 9'h015, 1'b0, 1'b0};
        vecs[11] = '{3, 9'h015, 1'b1, 2'b11, 9'h015, 1'b0, 1'b1};
        vecs[12] = '{3, 9'h01F, 1'b0, 2'b10, 9'h01F, 1'b1, 1'b0};
`ifdef UART_RX_MAJORITY_EN
        glitch_exp = 9'h031;
`else
        glitch_exp = 9'h030;
`endif

        for (int i = 0; i < 4; i++) rx_l[i] = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset ch%0d rx_data", i), {23'd0, data_w[i]}, 32'd0);
            check($sformatf("reset ch%0d flags", i),
                  {28'd0, done_w[i], ferr_w[i], perr_w[i], busy_w[i]}, 32'd0);
        end
        drive(0, 1'b1, BIT);

        // Latency of rx_busy, then false start.
        cnt0 = done_cnt[0];
        rx_l[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("busy_latency_2clk", {31'd0, busy_w[0]}, 32'd0);
        @(posedge clk);
        #1 check("busy_latency_3clk", {31'd0, busy_w[0]}, 32'd1);
        @(negedge clk);
        drive(0, 1'b0, BIT * 3000 / 10416 - 3);
        drive(0, 1'b1, BIT);
        check("false_start/busy", {31'd0, busy_w[0]}, 32'd0);
        check("false_start/done_count", done_cnt[0] - cnt0, 0);

        for (int i = 0; i < 13; i++) begin
            cnt0 = done_cnt[vecs[i].k];
            send(vecs[i].k, vecs[i].data, vecs[i].pbit, vecs[i].stops, 0, 0);
            check_frame($sformatf("vec%0d", i), vecs[i].k, cnt0,
                        vecs[i].exp_data, vecs[i].exp_ferr, vecs[i].exp_perr);
            drive(vecs[i].k, 1'b1, BIT / 2);
        end

        // Frame error followed by a long low: exactly one rx_done, then recovery.
        cnt0 = done_cnt[0];
        send(0, 9'h0A5, 1'b0, 2'b00, 0, 0);
        drive(0, 1'b0, 3 * BIT);
        check_frame("ferr_hold", 0, cnt0, 9'h0A5, 1'b1, 1'b0);
        drive(0, 1'b1, BIT);
        cnt0 = done_cnt[0];
        send(0, 9'h03C, 1'b0, 2'b11, 0, 0);
        check_frame("after_ferr", 0, cnt0, 9'h03C, 1'b0, 1'b0);
        drive(0, 1'b1, BIT);

        // Reset in the middle of data bit 4 of 0x55; the sender stops there too.
        cnt0 = done_cnt[0];
        drive(0, 1'b0, BIT);
        drive(0, 1'b1, BIT);
        drive(0, 1'b0, BIT);
        drive(0, 1'b1, BIT);
        drive(0, 1'b0, BIT);
        drive(0, 1'b1, BIT / 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b1, 2 * BIT);
        check("midreset/done_count", done_cnt[0] - cnt0, 0);
        check("midreset/rx_data", {23'd0, data_w[0]}, 32'd0);
        check("midreset/busy", {31'd0, busy_w[0]}, 32'd0);
        cnt0 = done_cnt[0];
        send(0, 9'h05A, 1'b0, 2'b11, 0, 0);
        check_frame("after_reset", 0, cnt0, 9'h05A, 1'b0, 1'b0);
        drive(0, 1'b1, BIT);

        // One-tick inversion centred on the bit-0 decision point of 0x31.
        cnt0 = done_cnt[0];
        send(0, 9'h031, 1'b0, 2'b11, BIT + BIT / 2 - DIV / 2, DIV);
        check_frame("glitch", 0, cnt0, glitch_exp, 1'b0, 1'b0);
        drive(0, 1'b1, BIT);

        // Random frames against the ones-count reference model.
        for (int n = 0; n < 16; n++) begin
            k  = $urandom_range(0, 3);
            db = cfg_db(k);
            d  = 9'($urandom);
            p  = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            ed = d & 9'((1 << db) - 1);
            ones = $countones(ed) + int'(p);
            case (cfg_pa(k))
                1: ep = ((ones % 2) == 0);
                2: ep = ((ones % 2) == 1);
                default: ep = 1'b0;
            endcase
            ef = (st[0] == 1'b0) || ((cfg_sb(k) == 2) && (st[1] == 1'b0));
            cnt0 = done_cnt[k];
            send(k, d, p, st, 0, 0);
            check_frame($sformatf("rand%0d_ch%0d_d%0h", n, k, d), k, cnt0, ed, ef, ep);
            drive(k, 1'b1, $urandom_range(3, BIT));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
